motor_step_sequencer: RTL
=========================

Name: motor_step_sequencer

Overview:
Stepper-motor phase sequencer driven by the motor AXI4-Lite register block's configuration outputs (start, stop, direction, step period, step count). It latches a move command, emits a timed sequence of coil patterns at a programmable rate, counts completed steps and reports busy/done/abort status back to the register block for software readback. One instance per motor channel; coil outputs go to the board driver pins.

Parameters:
PERIOD_W  24  width of cfg_period (clock cycles per step)
STEPS_W   16  width of cfg_steps and steps_done

Ports:
ACLK        in   1         system clock
ARESETN     in   1         asynchronous active-low reset
cfg_start   in   1         one-cycle pulse: begin a move
cfg_stop    in   1         level/pulse: abort current move
cfg_dir     in   1         1 = forward (index +1), 0 = reverse (index -1)
cfg_period  in   PERIOD_W  clock cycles per step
cfg_steps   in   STEPS_W   steps to execute
coil        out  4         coil drive pattern {D,C,B,A}
step_pulse  out  1         one-cycle pulse on every phase advance
busy        out  1         move in progress
done        out  1         sticky: last move completed normally
abort       out  1         sticky: last move ended by cfg_stop
steps_done  out  STEPS_W   steps executed in current/last move

Behaviour:
- Reset (ARESETN low, async): state IDLE; coil=4'b0000; step_pulse=0; busy=0; done=0; abort=0; steps_done=0; phase index=0; period counter=0. All outputs registered.
- FSM states: IDLE, RUN, FINISH.
- IDLE: on cfg_start, latch dir, period, steps; clear done, abort, steps_done; period counter=0.
  - latched steps==0 -> FINISH next cycle (no step, coil unchanged).
  - else -> RUN; coil driven with table[index] on the cycle after the start pulse (energize before first step); busy=1 from that cycle.
- Period clamp: latched period values 0 or 1 are treated as 2.
- RUN: counter increments each cycle; when counter==period-1: counter<=0, index advances per dir modulo table length, coil<=table[new index], step_pulse=1 for that cycle, steps_done+1. Step spacing = exactly period cycles; first step period cycles after RUN entry.
- When the step making steps_done==latched steps is issued -> FINISH.
- FINISH (1 cycle): busy<=0, done<=1, -> IDLE. Coil holds last pattern (holding torque) in IDLE.
- cfg_stop in RUN (any cycle, incl. a step cycle): no step issued that cycle; -> IDLE next cycle; coil<=0000; abort<=1; busy<=0; steps_done keeps value reached. cfg_stop in IDLE: coil<=0000 (release), flags unchanged.
- cfg_stop and cfg_start same cycle: stop wins; start ignored.
- cfg_start while busy: ignored; latched config unaffected; cfg_* changes mid-move have no effect.
- Phase index persists across moves (no re-zero except reset); reverse move from index 0 wraps to last entry.
- Full-step table (two-phase-on), index 0..3: 0011, 0110, 1100, 1001.
- steps_done width STEPS_W; cannot overflow (bounded by cfg_steps).
- Reset asserted mid-move: immediate return to reset values; no pending step emitted after release.

Optional Feature:
MOTOR_SEQ_HALFSTEP_EN
- Defined: 8-entry half-step table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001; index 3 bits; each step_pulse advances one half-step.
- Undefined: 4-entry full-step table above; index 2 bits. Ports and timing identical in both builds.

Test Plan:
- Reset, then start dir=1 period=10 steps=4 -> coil 0011 one cycle after start; step_pulse at +10,+20,+30,+40 cycles; coil 0110,1100,1001,0011; done=1, busy=0, steps_done=4, coil holds 0011.
- Following move dir=0 period=2 steps=3 -> coil 1001,1100,0110 two cycles apart; done=1, steps_done=3.
- Start period=100 steps=50, assert cfg_stop after 3rd step_pulse -> abort=1, done=0, steps_done=3, coil=0000, busy=0 next cycle.
- Start steps=0 -> no step_pulse; done=1 two cycles after start; coil unchanged; busy never high.
- Start period=0 steps=2, plus second cfg_start mid-move with steps=9 -> steps 2 cycles apart; second start ignored; steps_done=2.
- Build with MOTOR_SEQ_HALFSTEP_EN, dir=1 period=4 steps=8 from reset -> coil 0011,0010,0110,0100,1100,1000,1001,0001 (start coil 0001); steps_done=8.

Source files
------------

// File: rtl/motor_step_sequencer_if.sv
// motor_step_sequencer_if
// Configuration/status bundle between the motor register block (master) and
// one stepper phase sequencer channel (slave).
//   cfg_start   one-cycle pulse: begin a move
//   cfg_stop    level/pulse: abort the current move / release coils when idle
//   cfg_dir     1 = forward, 0 = reverse
//   cfg_period  clock cycles per step
//   cfg_steps   steps to execute
//   coil        coil drive pattern {D,C,B,A}
//   step_pulse  one-cycle pulse on every phase advance
//   busy        move in progress
//   done        sticky: last move completed normally
//   abort       sticky: last move ended by cfg_stop
//   steps_done  steps executed in the current/last move
interface motor_step_sequencer_if #(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned STEPS_W  = 16
);
    logic                cfg_start;
    logic                cfg_stop;
    logic                cfg_dir;
    logic [PERIOD_W-1:0] cfg_period;
    logic [STEPS_W-1:0]  cfg_steps;
    logic [3:0]          coil;
    logic                step_pulse;
    logic                busy;
    logic                done;
    logic                abort;
    logic [STEPS_W-1:0]  steps_done;

    modport master (
        output cfg_start, cfg_stop, cfg_dir, cfg_period, cfg_steps,
        input  coil, step_pulse, busy, done, abort, steps_done
    );

    modport slave (
        input  cfg_start, cfg_stop, cfg_dir, cfg_period, cfg_steps,
        output coil, step_pulse, busy, done, abort, steps_done
    );
endinterface

// File: rtl/motor_step_sequencer.sv
// motor_step_sequencer
// Stepper-motor phase sequencer. Latches a move command, advances the coil
// pattern every (clamped) period cycles, counts steps and reports
// busy/done/abort. All outputs are registered.
// Ports:
//   ACLK     system clock
//   ARESETN  asynchronous active-low reset
//   bus      motor_step_sequencer_if.slave (cfg_* in, coil/status out)
// Build option:
//   MOTOR_SEQ_HALFSTEP_EN  defined: 8-entry half-step table (3-bit index)
//                          undefined: 4-entry full-step table (2-bit index)
module motor_step_sequencer #(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned STEPS_W  = 16
) (
    input logic                   ACLK,
    input logic                   ARESETN,
    motor_step_sequencer_if.slave bus
);

`ifdef MOTOR_SEQ_HALFSTEP_EN
    localparam int unsigned IDX_W = 3;

    function automatic logic [3:0] coil_lut(input logic [IDX_W-1:0] idx);
        logic [3:0] pat;
        unique case (idx)
            3'd0:    pat = 4'b0001;
            3'd1:    pat = 4'b0011;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b1100;
            3'd6:    pat = 4'b1000;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction
`else
    localparam int unsigned IDX_W = 2;

    function automatic logic [3:0] coil_lut(input logic [IDX_W-1:0] idx);
        logic [3:0] pat;
        unique case (idx)
            2'd0:    pat = 4'b0011;
            2'd1:    pat = 4'b0110;
            2'd2:    pat = 4'b1100;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t              state_q;
    logic                dir_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [STEPS_W-1:0]  steps_q;
    logic [STEPS_W-1:0]  sd_q, sd_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          coil_q;
    logic                pulse_q, busy_q, done_q, abort_q;
    logic                step_now;
    logic [PERIOD_W-1:0] period_clamped;

    // Index wraps naturally at the table length since the table size is a
    // power of two.
    always_comb begin
        idx_d          = dir_q ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
        sd_d           = sd_q + STEPS_W'(1);
        step_now       = (cnt_q == period_q - PERIOD_W'(1));
        period_clamped = (bus.cfg_period < PERIOD_W'(2)) ? PERIOD_W'(2) : bus.cfg_period;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            period_q <= '0;
            cnt_q    <= '0;
            steps_q  <= '0;
            sd_q     <= '0;
            idx_q    <= '0;
            coil_q   <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Stop has priority over a simultaneous start.
                    if (bus.cfg_stop) begin
                        coil_q <= '0;
                    end else if (bus.cfg_start) begin
                        dir_q    <= bus.cfg_dir;
                        period_q <= period_clamped;
                        steps_q  <= bus.cfg_steps;
                        done_q   <= 1'b0;
                        abort_q  <= 1'b0;
                        sd_q     <= '0;
                        cnt_q    <= '0;
                        if (bus.cfg_steps == '0) begin
                            state_q <= FINISH;
                        end else begin
                            state_q <= RUN;
                            coil_q  <= coil_lut(idx_q);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.cfg_stop) begin
                        state_q <= IDLE;
                        coil_q  <= '0;
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (step_now) begin
                        cnt_q   <= '0;
                        idx_q   <= idx_d;
                        coil_q  <= coil_lut(idx_d);
                        pulse_q <= 1'b1;
                        sd_q    <= sd_d;
                        if (sd_d == steps_q) begin
                            state_q <= FINISH;
                        end
                    end else begin
                        cnt_q <= cnt_q + PERIOD_W'(1);
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.coil       = coil_q;
    assign bus.step_pulse = pulse_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.abort      = abort_q;
    assign bus.steps_done = sd_q;

endmodule
